// File: rtl/fifo2sl_core.sv
// fifo2sl_core: core-clock end of the APB/async-FIFO bridge.
// Pops {mod,data} commands, drives the SL transmitter, and pushes
// echoes, received words and status bytes back toward APB.
// Ports: clk, reset (async, active-high); cmd_fifo_* pop side;
// rsp_fifo_* push side; tx_* transmitter; rx_* receiver;
// config_out / channel_out applied registers.
// Optional: define SL_LOOPBACK_EN so config_out[LOOPBACK_BIT]
// routes data commands into the rx buffer instead of the
// transmitter.
module fifo2sl_core #(
  parameter int CONFIG_REG_WIDTH  = 16,
  parameter int CHANNEL_REG_WIDTH = 2,
  parameter int LOOPBACK_BIT      = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_fifo_empty,
  input  logic [33:0]                  cmd_fifo_data,
  output logic                         cmd_fifo_inc,
  input  logic                         rsp_fifo_full,
  output logic [33:0]                  rsp_fifo_data,
  output logic                         rsp_fifo_inc,
  output logic [31:0]                  tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  input  logic [31:0]                  rx_data,
  input  logic                         rx_valid,
  input  logic                         rx_err,
  output logic [CONFIG_REG_WIDTH-1:0]  config_out,
  output logic [CHANNEL_REG_WIDTH-1:0] channel_out
);

  localparam logic [1:0] M_CFG  = 2'd0;
  localparam logic [1:0] M_DATA = 2'd1;
  localparam logic [1:0] M_STAT = 2'd2;
  localparam logic [1:0] M_CHAN = 2'd3;

  typedef enum logic [3:0] {
    C_IDLE = 4'b0001,
    C_DEC  = 4'b0010,
    C_ECHO = 4'b0100,
    C_TX   = 4'b1000
  } state_t;

  state_t      state;
  logic [33:0] cmd_q;
  logic        pop_hold;

  logic [31:0] rx_buf;
  logic        rx_full;
  logic        rx_ovf;
  logic        rx_err_s;
  logic [7:0]  last_status;

  logic [7:0]  status;
  logic        echo_req;
  logic        stat_req;
  logic        can_push;
  logic        gnt_echo;
  logic        gnt_rx;
  logic        gnt_stat;
  logic [31:0] echo_val;
  logic        lb_hit;

  assign status   = {4'b0, rx_err_s, rx_ovf, rx_full, tx_busy};
  assign echo_req = (state == C_ECHO);
  assign stat_req = (status != last_status);
  // a push cycle blocks the next one so the full flag can settle
  assign can_push = !rsp_fifo_full && !rsp_fifo_inc;
  assign gnt_echo = can_push && echo_req;
  assign gnt_rx   = can_push && !echo_req && rx_full;
  assign gnt_stat = can_push && !echo_req && !rx_full
                    && stat_req;

  assign echo_val = (cmd_q[33:32] == M_CFG)
                    ? 32'(config_out) : 32'(channel_out);

`ifdef SL_LOOPBACK_EN
  assign lb_hit = (state == C_TX) && config_out[LOOPBACK_BIT];
`else
  // loopback bit is an ordinary config bit in this build
  assign lb_hit = 1'b0 & config_out[LOOPBACK_BIT];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= C_IDLE;
      cmd_q        <= '0;
      pop_hold     <= 1'b0;
      cmd_fifo_inc <= 1'b0;
      config_out   <= '0;
      channel_out  <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
    end else begin
      cmd_fifo_inc <= 1'b0;
      tx_start     <= 1'b0;
      pop_hold     <= 1'b0;
      unique case (1'b1)
        (state == C_IDLE): begin
          if (!cmd_fifo_empty && !pop_hold) begin
            cmd_q        <= cmd_fifo_data;
            cmd_fifo_inc <= 1'b1;
            state        <= C_DEC;
          end
        end
        (state == C_DEC): begin
          unique case (cmd_q[33:32])
            M_CFG: begin
              config_out <= cmd_q[CONFIG_REG_WIDTH-1:0];
              state      <= C_ECHO;
            end
            M_CHAN: begin
              channel_out <= cmd_q[CHANNEL_REG_WIDTH-1:0];
              state       <= C_ECHO;
            end
            M_DATA: begin
              tx_data <= cmd_q[31:0];
              state   <= C_TX;
            end
            default: begin
              // discarded word: hold off one cycle so pops
              // stay at least three cycles apart
              pop_hold <= 1'b1;
              state    <= C_IDLE;
            end
          endcase
        end
        (state == C_ECHO): begin
          if (gnt_echo) state <= C_IDLE;
        end
        (state == C_TX): begin
          if (lb_hit) begin
            state <= C_IDLE;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= C_IDLE;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_fifo_inc  <= 1'b0;
      rsp_fifo_data <= '0;
      rx_buf        <= '0;
      rx_full       <= 1'b0;
      rx_ovf        <= 1'b0;
      rx_err_s      <= 1'b0;
      last_status   <= '0;
    end else begin
      rsp_fifo_inc <= 1'b0;
      if (gnt_echo) begin
        rsp_fifo_inc  <= 1'b1;
        rsp_fifo_data <= {cmd_q[33:32], echo_val};
      end else if (gnt_rx) begin
        rsp_fifo_inc  <= 1'b1;
        rsp_fifo_data <= {M_DATA, rx_buf};
        rx_full       <= 1'b0;
      end else if (gnt_stat) begin
        rsp_fifo_inc  <= 1'b1;
        rsp_fifo_data <= {M_STAT, 24'b0, status};
        last_status   <= status;
        rx_ovf        <= 1'b0;
        rx_err_s      <= 1'b0;
      end
      // arrivals come after the grant so set events win;
      // rx_full is still 1 in the push cycle, so a word
      // arriving then is dropped
      if (rx_valid || lb_hit) begin
        if (rx_full || (rx_valid && lb_hit)) rx_ovf <= 1'b1;
        if (!rx_full) begin
          rx_full <= 1'b1;
          rx_buf  <= lb_hit ? tx_data : rx_data;
        end
      end
      if (rx_err) rx_err_s <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo2sl_core.sv
// tb_fifo2sl_core: scoreboard bench for fifo2sl_core.
// Directed commands/rx events; monitor pops expected pushes.
module tb_fifo2sl_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_fifo_empty;
  logic [33:0] cmd_fifo_data;
  logic        cmd_fifo_inc;
  logic        rsp_fifo_full;
  logic [33:0] rsp_fifo_data;
  logic        rsp_fifo_inc;
  logic [31:0] tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [15:0] config_out;
  logic [1:0]  channel_out;

  always #5 clk = ~clk;

  fifo2sl_core dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_fifo_empty (cmd_fifo_empty),
    .cmd_fifo_data  (cmd_fifo_data),
    .cmd_fifo_inc   (cmd_fifo_inc),
    .rsp_fifo_full  (rsp_fifo_full),
    .rsp_fifo_data  (rsp_fifo_data),
    .rsp_fifo_inc   (rsp_fifo_inc),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_err         (rx_err),
    .config_out     (config_out),
    .channel_out    (channel_out)
  );

  // show-ahead command FIFO model
  logic [33:0] cmd_mem [0:63];
  int          cmd_wr = 0;
  int          cmd_rd = 0;
  assign cmd_fifo_empty = (cmd_wr == cmd_rd);
  assign cmd_fifo_data  = cmd_mem[cmd_rd[5:0]];
  always @(posedge clk)
    if (cmd_fifo_inc) cmd_rd <= cmd_rd + 1;

  logic [33:0] exp_rsp [$];
  logic [31:0] exp_tx  [$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_pop = -100;

  task automatic chk(input string nm,
                     input logic [33:0] act,
                     input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [33:0] w);
    cmd_mem[cmd_wr[5:0]] = w;
    cmd_wr++;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_tx.size() != 0
            || !cmd_fifo_empty) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 34'(exp_rsp.size() + exp_tx.size()), 34'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_cinc"}, 34'(cmd_fifo_inc), 34'd0);
    chk({nm, "_rdat"}, rsp_fifo_data, 34'd0);
    chk({nm, "_rinc"}, 34'(rsp_fifo_inc), 34'd0);
    chk({nm, "_txd"}, 34'(tx_data), 34'd0);
    chk({nm, "_txs"}, 34'(tx_start), 34'd0);
    chk({nm, "_cfg"}, 34'(config_out), 34'd0);
    chk({nm, "_chn"}, 34'(channel_out), 34'd0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rsp_fifo_inc) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL rsp_extra: got %h expected none",
                   rsp_fifo_data);
        end else begin
          chk("rsp_push", rsp_fifo_data, exp_rsp.pop_front());
        end
      end
      if (tx_start) begin
        if (exp_tx.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL tx_extra: got %h expected none",
                   tx_data);
        end else begin
          chk("tx_launch", 34'(tx_data), 34'(exp_tx.pop_front()));
        end
      end
      if (cmd_fifo_inc) begin
        checks++;
        if (cyc - last_pop < 3) begin
          fails++;
          $display("FAIL pop_gap: got %0d expected >=3",
                   cyc - last_pop);
        end
        last_pop = cyc;
      end
    end
  endtask

  task automatic stimulus();
    reset = 1'b1;
    rsp_fifo_full = 1'b0;
    tx_busy = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset0");
    reset = 1'b0;

    // T1: reset while stalled in C_TX
    rsp_fifo_full = 1'b1;
    tx_busy = 1'b1;
    push_cmd({2'd1, 32'h1111_0000});
    repeat (8) @(negedge clk);
    chk("t1_txd_held", 34'(tx_data), 34'h1111_0000);
    reset = 1'b1;
    #1;
    chk_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    tx_busy = 1'b0;
    rsp_fifo_full = 1'b0;
    exp_tx.push_back(32'hA5A5_0001);
    push_cmd({2'd1, 32'hA5A5_0001});
    drain("t1_drain");

    // T2: config and channel echoes
    exp_rsp.push_back({2'd0, 32'h0000_1234});
    push_cmd({2'd0, 32'h0000_1234});
    drain("t2a_drain");
    chk("t2_cfg", 34'(config_out), 34'h1234);
    exp_rsp.push_back({2'd3, 32'h0000_0003});
    push_cmd({2'd3, 32'h0000_0003});
    drain("t2b_drain");
    chk("t2_chn", 34'(channel_out), 34'h3);

    // T3: held tx_busy stalls the launch
    exp_rsp.push_back({2'd2, 32'h01});
    tx_busy = 1'b1;
    push_cmd({2'd1, 32'hCAFE_0003});
    repeat (10) @(negedge clk);
    exp_tx.push_back(32'hCAFE_0003);
    exp_rsp.push_back({2'd2, 32'h00});
    tx_busy = 1'b0;
    drain("t3_drain");

    // T4: overflow while response FIFO full, then rx_err
    rsp_fifo_full = 1'b1;
    rx_valid = 1'b1;
    rx_data = 32'h1111_1111;
    @(negedge clk);
    rx_data = 32'h2222_2222;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    exp_rsp.push_back({2'd1, 32'h1111_1111});
    exp_rsp.push_back({2'd2, 32'h04});
    exp_rsp.push_back({2'd2, 32'h00});
    rsp_fifo_full = 1'b0;
    drain("t4a_drain");
    exp_rsp.push_back({2'd2, 32'h08});
    exp_rsp.push_back({2'd2, 32'h00});
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    drain("t4b_drain");

    // T5: back-to-back commands incl. a discarded one
    exp_rsp.push_back({2'd0, 32'h0000_00AB});
    exp_rsp.push_back({2'd3, 32'h0000_0001});
    exp_tx.push_back(32'h1234_5678);
    push_cmd({2'd2, 32'h0000_FFFF});
    push_cmd({2'd0, 32'h0000_00AB});
    push_cmd({2'd3, 32'h0000_0001});
    push_cmd({2'd1, 32'h1234_5678});
    drain("t5_drain");
    chk("t5_cfg", 34'(config_out), 34'hAB);
    chk("t5_chn", 34'(channel_out), 34'h1);

    // T6: loopback bit set
    exp_rsp.push_back({2'd0, 32'h0000_8000});
`ifdef SL_LOOPBACK_EN
    exp_rsp.push_back({2'd1, 32'hDEAD_BEEF});
`else
    exp_tx.push_back(32'hDEAD_BEEF);
`endif
    push_cmd({2'd0, 32'h0000_8000});
    push_cmd({2'd1, 32'hDEAD_BEEF});
    drain("t6_drain");
    chk("t6_cfg", 34'(config_out), 34'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
  end

endmodule
